// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit lookahead segment per stage,
// globally stalled by output back-pressure, one operation per cycle when unstalled.
module pipelined_cla_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);
    localparam int NSEG = WIDTH / BLOCK;

    logic             r_run;
    logic             w_en;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin0;

    // Handshake: a transfer happens on an edge where valid & ready; the pipe advances as a
    // whole whenever the last stage is empty or being drained (out_ready), and in_ready
    // follows that advance so nothing is dropped while stalled.
    assign w_en     = ~(out_valid & ~out_ready);
    assign in_ready = r_run & w_en;
    assign w_b_eff  = in_sub ? ~in_b : in_b;
    assign w_cin0   = in_cin ^ in_sub;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // Carries of one segment in group generate/propagate form, so cin never ripples.
    function automatic logic [BLOCK:0] seg_carries(input logic [BLOCK-1:0] a,
                                                   input logic [BLOCK-1:0] b,
                                                   input logic             cin);
        logic           gg;
        logic           pp;
        logic [BLOCK:0] c;
        c    = '0;
        c[0] = cin;
        gg   = 1'b0;
        pp   = 1'b1;
        for (int i = 0; i < BLOCK; i++) begin
            gg       = (a[i] & b[i]) | ((a[i] ^ b[i]) & gg);
            pp       = pp & (a[i] ^ b[i]);
            c[i + 1] = gg | (pp & cin);
        end
        return c;
    endfunction

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        logic [BLOCK-1:0]       w_seg_a;
        logic [BLOCK-1:0]       w_seg_b;
        logic [BLOCK-1:0]       w_seg_s;
        logic                   w_seg_cin;
        logic                   w_vin;
        logic                   w_load;
        logic [BLOCK:0]         w_c;
        logic [(k+1)*BLOCK-1:0] w_sum_nxt;
        logic                   r_valid;
        logic                   r_carry;
        logic [(k+1)*BLOCK-1:0] r_sum;

        if (k == 0) begin : g_first
            assign w_seg_a   = in_a[BLOCK-1:0];
            assign w_seg_b   = w_b_eff[BLOCK-1:0];
            assign w_seg_cin = w_cin0;
            assign w_vin     = in_valid & r_run;
            assign w_sum_nxt = w_seg_s;
        end else begin : g_next
            assign w_seg_a   = g_stage[k-1].g_ops.r_a[BLOCK-1:0];
            assign w_seg_b   = g_stage[k-1].g_ops.r_b[BLOCK-1:0];
            assign w_seg_cin = g_stage[k-1].r_carry;
            assign w_vin     = g_stage[k-1].r_valid;
            assign w_sum_nxt = {w_seg_s, g_stage[k-1].r_sum};
        end

        assign w_c     = seg_carries(w_seg_a, w_seg_b, w_seg_cin);
        assign w_seg_s = w_seg_a ^ w_seg_b ^ w_c[BLOCK-1:0];
        // Data registers only load real operations, so bubbles never capture idle inputs.
        assign w_load  = w_en & w_vin;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_valid <= 1'b0;
                r_carry <= 1'b0;
                r_sum   <= '0;
            end else begin
                if (w_en) begin
                    r_valid <= w_vin;
                end
                if (w_load) begin
                    r_carry <= w_c[BLOCK];
                    r_sum   <= w_sum_nxt;
                end
            end
        end

        if (k < NSEG - 1) begin : g_ops
            localparam int UP = WIDTH - (k + 1) * BLOCK;
            logic [UP-1:0] w_a_up;
            logic [UP-1:0] w_b_up;
            logic [UP-1:0] r_a;
            logic [UP-1:0] r_b;

            if (k == 0) begin : g_src_in
                assign w_a_up = in_a[WIDTH-1:BLOCK];
                assign w_b_up = w_b_eff[WIDTH-1:BLOCK];
            end else begin : g_src_prev
                assign w_a_up = g_stage[k-1].g_ops.r_a[WIDTH-k*BLOCK-1:BLOCK];
                assign w_b_up = g_stage[k-1].g_ops.r_b[WIDTH-k*BLOCK-1:BLOCK];
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_load) begin
                    r_a <= w_a_up;
                    r_b <= w_b_up;
                end
            end
        end

        if (k == NSEG - 1) begin : g_last
            logic r_cmsb;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_cmsb <= 1'b0;
                end else if (w_load) begin
                    r_cmsb <= w_c[BLOCK-1];
                end
            end

            assign out_valid = r_valid;
            assign out_sum   = r_sum;
            assign out_cout  = r_carry;
            assign out_ovf   = r_cmsb ^ r_carry;
            // Qualified by valid so the flag reads 0 in reset and on an empty pipe.
            assign out_zero  = r_valid & ~|r_sum;
        end
    end
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: four instances (32/8, 32/32, 16/4, 64/8), table vectors,
// cycle-exact streaming, stall/back-pressure scoreboard and mid-stream reset.
module tb_pipelined_cla_adder;
    localparam int NDUT = 4;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        d_in_valid  [NDUT];
    logic        d_in_ready  [NDUT];
    logic [63:0] d_a         [NDUT];
    logic [63:0] d_b         [NDUT];
    logic        d_sub       [NDUT];
    logic        d_cin       [NDUT];
    logic        d_out_valid [NDUT];
    logic        d_out_ready [NDUT];
    logic [63:0] d_sum       [NDUT];
    logic        d_cout      [NDUT];
    logic        d_ovf       [NDUT];
    logic        d_zero      [NDUT];

    int   checks = 0;
    int   errors = 0;
    int   cfg_w [NDUT] = '{32, 32, 16, 64};
    int   cfg_n [NDUT] = '{4, 1, 4, 8};
    res_t exp_q[$];
    vec_t vecs[9];

    always #5 clock = ~clock;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        localparam int W = (gi == 2) ? 16 : (gi == 3) ? 64 : 32;
        localparam int B = (gi == 1) ? 32 : (gi == 2) ? 4 : 8;
        logic [W-1:0] w_sum;

        pipelined_cla_adder #(.WIDTH(W), .BLOCK(B)) u_dut (
            .clock     (clock),
            .reset_n   (reset_n),
            .in_valid  (d_in_valid[gi]),
            .in_ready  (d_in_ready[gi]),
            .in_a      (d_a[gi][W-1:0]),
            .in_b      (d_b[gi][W-1:0]),
            .in_sub    (d_sub[gi]),
            .in_cin    (d_cin[gi]),
            .out_valid (d_out_valid[gi]),
            .out_ready (d_out_ready[gi]),
            .out_sum   (w_sum),
            .out_cout  (d_cout[gi]),
            .out_ovf   (d_ovf[gi]),
            .out_zero  (d_zero[gi])
        );
        assign d_sum[gi] = 64'(w_sum);
    end

    // Reference: plain modular arithmetic with one extra bit for the carry.
    function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic sub, input logic cin, input int w);
        logic [63:0] mask;
        logic [63:0] aa;
        logic [63:0] bb;
        logic [64:0] full;
        res_t        r;
        mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        aa     = a & mask;
        bb     = (sub ? ~b : b) & mask;
        full   = {1'b0, aa} + {1'b0, bb} + 65'(cin ^ sub);
        r.sum  = full[63:0] & mask;
        r.cout = full[w];
        r.ovf  = (aa[w-1] == bb[w-1]) && (r.sum[w-1] != aa[w-1]);
        r.zero = (r.sum == 64'd0);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string name, input int idx, input res_t e);
        chk({name, "_sum"},  d_sum[idx],  e.sum);
        chk({name, "_cout"}, d_cout[idx], e.cout);
        chk({name, "_ovf"},  d_ovf[idx],  e.ovf);
        chk({name, "_zero"}, d_zero[idx], e.zero);
    endtask

    task automatic chk_reset_state(input string name, input int idx);
        chk({name, "_out_valid"}, d_out_valid[idx], 1'b0);
        chk({name, "_in_ready"},  d_in_ready[idx],  1'b0);
        chk_out(name, idx, '0);
    endtask

    task automatic drive_op(input int idx, input logic [63:0] a, input logic [63:0] b,
                            input logic sub, input logic cin);
        d_in_valid[idx] = 1'b1;
        d_a[idx]        = a;
        d_b[idx]        = b;
        d_sub[idx]      = sub;
        d_cin[idx]      = cin;
    endtask

    task automatic drive_idle(input int idx);
        d_in_valid[idx] = 1'b0;
        d_a[idx]        = {$urandom, $urandom};
        d_b[idx]        = {$urandom, $urandom};
        d_sub[idx]      = 1'($urandom_range(0, 1));
        d_cin[idx]      = 1'($urandom_range(0, 1));
    endtask

    // One isolated operation; checks out_valid stays low until exactly nseg edges.
    task automatic run_single(input string name, input int idx, input int nseg,
                              input vec_t v);
        res_t e;
        e.sum  = 64'(v.sum);
        e.cout = v.cout;
        e.ovf  = v.ovf;
        e.zero = v.zero;
        @(negedge clock);
        d_out_ready[idx] = 1'b1;
        drive_op(idx, 64'(v.a), 64'(v.b), v.sub, v.cin);
        #1;
        chk({name, "_in_ready"}, d_in_ready[idx], 1'b1);
        for (int c = 1; c <= nseg; c++) begin
            @(negedge clock);
            drive_idle(idx);
            #1;
            if (c < nseg) begin
                chk({name, "_early_valid"}, d_out_valid[idx], 1'b0);
            end else begin
                chk({name, "_valid"}, d_out_valid[idx], 1'b1);
                chk_out(name, idx, e);
            end
        end
    endtask

    // Back-to-back ops with out_ready=1; op j must be on out_* exactly after edge j+nseg-1.
    task automatic stream(input string name, input int idx, input int nops);
        res_t        e[$];
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic        cin;
        int          j;
        for (int c = 0; c <= nops + cfg_n[idx] + 1; c++) begin
            @(negedge clock);
            d_out_ready[idx] = 1'b1;
            #1;
            j = c - cfg_n[idx];
            if (j >= 0 && j < nops) begin
                chk({name, "_valid"}, d_out_valid[idx], 1'b1);
                chk_out(name, idx, e[j]);
            end else begin
                chk({name, "_idle_valid"}, d_out_valid[idx], 1'b0);
            end
            if (c < nops) begin
                if (c == 0) begin
                    a = 64'h0000_0000_00FF_FFFF;
                    b = 64'd1;
                    sub = 1'b0;
                    cin = 1'b0;
                end else begin
                    a = {$urandom, $urandom};
                    b = {$urandom, $urandom};
                    sub = 1'($urandom_range(0, 1));
                    cin = 1'($urandom_range(0, 1));
                end
                e.push_back(model(a, b, sub, cin, cfg_w[idx]));
                drive_op(idx, a, b, sub, cin);
                chk({name, "_in_ready"}, d_in_ready[idx], 1'b1);
            end else begin
                drive_idle(idx);
            end
        end
    endtask

    // One cycle of scoreboarded traffic on instance idx.
    task automatic step(input int idx, input logic ordy, input logic ivld);
        res_t        r;
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic        cin;
        @(negedge clock);
        d_out_ready[idx] = ordy;
        #1;
        if (d_out_valid[idx] && ordy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra: got unexpected result %0h expected none", d_sum[idx]);
            end else begin
                r = exp_q.pop_front();
                chk_out("sb", idx, r);
            end
        end
        if (ivld) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            sub = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
            drive_op(idx, a, b, sub, cin);
            if (d_in_ready[idx]) begin
                exp_q.push_back(model(a, b, sub, cin, cfg_w[idx]));
            end
        end else begin
            drive_idle(idx);
        end
    endtask

    task automatic drain(input string name, input int idx);
        for (int c = 0; c < 20; c++) begin
            step(idx, 1'b1, 1'b0);
        end
        chk({name, "_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};

        for (int i = 0; i < NDUT; i++) begin
            d_out_ready[i] = 1'b1;
            drive_idle(i);
        end
        reset_n = 1'b1;
        #1;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        for (int i = 0; i < NDUT; i++) begin
            chk_reset_state("reset", i);
        end
        reset_n = 1'b1;
        #1;
        chk("release_in_ready_low", d_in_ready[0], 1'b0);
        @(negedge clock);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            chk("release_in_ready_high", d_in_ready[i], 1'b1);
        end

        for (int v = 0; v < 9; v++) begin
            run_single($sformatf("vec%0d", v), 0, cfg_n[0], vecs[v]);
        end

        stream("stream32_8", 0, 16);

        exp_q.delete();
        repeat (6) step(0, 1'b1, 1'b1);
        for (int s = 0; s < 5; s++) begin
            step(0, 1'b0, 1'b1);
            chk("stall_in_ready", d_in_ready[0], 1'b0);
            chk("stall_out_valid", d_out_valid[0], 1'b1);
            if (exp_q.size() > 0) begin
                chk_out("stall_hold", 0, exp_q[0]);
            end
        end
        drain("stall_drain", 0);

        for (int s = 0; s < 60; s++) begin
            step(0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
        end
        drain("random_drain", 0);

        repeat (3) step(0, 1'b1, 1'b1);
        @(negedge clock);
        drive_idle(0);
        reset_n = 1'b0;
        #1;
        chk_reset_state("midreset", 0);
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            drive_idle(0);
            #1;
            chk("midreset_no_stale", d_out_valid[0], 1'b0);
        end

        stream("sweep32_32", 1, 16);
        stream("sweep16_4", 2, 16);
        stream("sweep64_8", 3, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
